// File: rtl/ffs_sub_pkg.sv
// Shared definitions for the Curve25519 prime-field datapath:
// field width, modulus constant and the field-element type.
package ffs_sub_pkg;

    localparam int FIELD_W = 255;

    typedef logic [FIELD_W-1:0] fe_t;

    // 2^255 - 19: every bit set except the low five, which hold 5'b01101.
    localparam fe_t P25519 = {{(FIELD_W-5){1'b1}}, 5'b01101};

    // Stage-1 pipeline register: raw difference with its borrow in the top bit.
    typedef struct packed {
        logic               vld;
        logic [FIELD_W:0]   diff;
    } s1_t;

    function automatic logic [FIELD_W:0] sub_wide(input fe_t x, input fe_t y);
        return {1'b0, x} - {1'b0, y};
    endfunction

endpackage

// File: rtl/ffs_sub_if.sv
// Request/result bundle for the field subtractor: operands and strobe in,
// registered result and one-cycle valid out.
interface ffs_sub_if;
    import ffs_sub_pkg::*;

    logic start;
    fe_t  a;
    fe_t  b;
    fe_t  result;
    logic valid;

    modport master (output start, output a, output b, input result, input valid);
    modport slave  (input start, input a, input b, output result, output valid);

endinterface

// File: rtl/ffs_sub_reduce.sv
// Folds a 256-bit borrow-carrying difference back into the field by adding P
// when the subtraction underflowed. Shared with the field adder.
module ffs_sub_reduce
    import ffs_sub_pkg::*;
(
    input  logic [FIELD_W:0] diff,
    output fe_t              res
);

    always_comb begin
        // NOTE: assign a default before any conditional update so no path
        // leaves res unassigned, which would infer a latch.
        res = diff[FIELD_W-1:0];
        if (diff[FIELD_W]) begin
            // The carry out of this add is exactly the borrow being cancelled.
            res = diff[FIELD_W-1:0] + P25519;
        end
    end

endmodule

// File: rtl/ffs_sub.sv
// Two-stage pipelined (a - b) mod (2^255 - 19): stage 1 subtracts, stage 2
// conditionally adds P and registers the result with a one-cycle valid.
module ffs_sub
    import ffs_sub_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    ffs_sub_if.slave  bus
);

    s1_t s1_q;
    fe_t reduced;

    ffs_sub_reduce u_reduce (
        .diff (s1_q.diff),
        .res  (reduced)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            s1_q       <= '0;
            bus.result <= '0;
            bus.valid  <= 1'b0;
        end else begin
            s1_q.vld  <= bus.start;
            if (bus.start) begin
                s1_q.diff <= sub_wide(bus.a, bus.b);
            end

            // result holds between completions; valid is a pure pulse.
            bus.valid <= s1_q.vld;
            if (s1_q.vld) begin
                bus.result <= reduced;
            end
        end
    end

endmodule

// File: tb/tb_ffs_sub.sv
// Directed and randomized checks of the Curve25519 field subtractor:
// latency, holding, back-to-back issue, reset discard and a reference model.
module tb_ffs_sub;
    import ffs_sub_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ffs_sub_if bus ();

    ffs_sub u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam fe_t WRAP_A   = 255'd44927731495623270119727621215091840270797887326986279676957494683529379806913;
    localparam fe_t WRAP_B   = 255'd45965849458578823337785628114947185621072782472466027602082789798859530730301;
    localparam fe_t WRAP_R   = 255'd56857926655702544493727485604488608576360097187340534094603496888626413896561;
    localparam fe_t P_DEC    = 255'd57896044618658097711785492504343953926634992332820282019728792003956564819949;
    localparam fe_t P_M7     = 255'd57896044618658097711785492504343953926634992332820282019728792003956564819942;
    localparam fe_t P_M1     = 255'd57896044618658097711785492504343953926634992332820282019728792003956564819948;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic fe_t ref_sub(input fe_t x, input fe_t y);
        if (x >= y) return x - y;
        return P_DEC - (y - x);
    endfunction

    function automatic fe_t rand_fe();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        w[255] = 1'b0;
        if (w >= {1'b0, P_DEC}) w = w - {1'b0, P_DEC};
        return w[254:0];
    endfunction

    // Issue one operation and follow it through its full latency window.
    task automatic run_single(input string tag, input fe_t x, input fe_t y, input fe_t exp);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = '1;
        bus.b     = '0;
        check({tag, "_v_e0"}, bus.valid, 1'b0);
        @(negedge clk);
        check({tag, "_v_e1"}, bus.valid, 1'b1);
        check({tag, "_res"}, bus.result, exp);
        @(negedge clk);
        check({tag, "_v_after"}, bus.valid, 1'b0);
        check({tag, "_hold"}, bus.result, exp);
    endtask

    // Scoreboard for the random phase.
    fe_t exp_q[$];
    bit  sb_on     = 1'b0;
    int  n_starts  = 0;
    int  n_valids  = 0;

    always @(negedge clk) begin
        if (sb_on && bus.valid) begin
            n_valids++;
            if (exp_q.size() == 0) begin
                check("rnd_spurious_valid", 1'b1, 1'b0);
            end else begin
                check("rnd_result", bus.result, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(negedge clk);
        check("p_const", P25519, P_DEC);
        check("reset_valid", bus.valid, 1'b0);
        check("reset_result", bus.result, '0);
        rst = 1'b0;
        @(negedge clk);

        run_single("wrap", WRAP_A, WRAP_B, WRAP_R);
        run_single("no_borrow", 255'd10, 255'd3, 255'd7);
        run_single("borrow", 255'd3, 255'd10, P_M7);
        run_single("equal", 255'd12345, 255'd12345, '0);
        run_single("zero_minus_pm1", '0, P_M1, 255'd1);
        run_single("pm1_minus_zero", P_M1, '0, P_M1);

        // Back-to-back issue: (10,3), (3,10), (5,5).
        bus.start = 1'b1; bus.a = 255'd10; bus.b = 255'd3;
        @(negedge clk);
        check("b2b_v0", bus.valid, 1'b0);
        bus.a = 255'd3; bus.b = 255'd10;
        @(negedge clk);
        check("b2b_v1", bus.valid, 1'b1);
        check("b2b_r1", bus.result, 255'd7);
        bus.a = 255'd5; bus.b = 255'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_v2", bus.valid, 1'b1);
        check("b2b_r2", bus.result, P_M7);
        @(negedge clk);
        check("b2b_v3", bus.valid, 1'b1);
        check("b2b_r3", bus.result, '0);
        @(negedge clk);
        check("b2b_v4", bus.valid, 1'b0);
        check("b2b_hold", bus.result, '0);

        // Load a nonzero result so the reset clear is observable.
        run_single("pre_reset", 255'd10, 255'd3, 255'd7);

        // Reset while an operation is in stage 1: it must be discarded.
        bus.start = 1'b1; bus.a = 255'd10; bus.b = 255'd3;
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", bus.valid, 1'b0);
        check("rst_mid_result", bus.result, '0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_no_pulse", bus.valid, 1'b0);

        // start held during reset is ignored.
        rst = 1'b1;
        bus.start = 1'b1; bus.a = 255'd20; bus.b = 255'd1;
        repeat (2) @(negedge clk);
        check("rst_start_v", bus.valid, 1'b0);
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_start_after", bus.valid, 1'b0);
        end
        check("rst_start_result", bus.result, '0);

        // Random phase: 1000 operations with random idle gaps.
        sb_on = 1'b1;
        while (n_starts < 1000) begin
            if ($urandom_range(3) != 0) begin
                fe_t x;
                fe_t y;
                x = rand_fe();
                y = rand_fe();
                bus.start = 1'b1;
                bus.a = x;
                bus.b = y;
                exp_q.push_back(ref_sub(x, y));
                n_starts++;
            end else begin
                bus.start = 1'b0;
                bus.a = rand_fe();
                bus.b = rand_fe();
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        sb_on = 1'b0;
        check("rnd_valid_count", n_valids, n_starts);
        check("rnd_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
